layer_compositor: RTL

- N-layer successor to the single-window drawing path: maps VGA raster coordinates into NUM_LAYERS independently placed rectangular windows, hands local coordinates to each layer renderer, and merges returned pixels by fixed priority over a background colour.
- Window placement and debug mode are double-buffered and update only on frame_stb, so a frame never tears.
- Sits between the VGA timing generator and the VGA output pins.

---
 rtl/layer_compositor.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/layer_compositor.sv
// Maps the VGA raster into NUM_LAYERS prioritised windows, hands local coordinates to the
// layer renderers and composites their returned pixels over a live background colour.
module layer_compositor #(
  parameter int H_ADDR_WIDTH  = 10,
  parameter int V_ADDR_WIDTH  = 10,
  parameter int NUM_LAYERS    = 2,
  parameter int COLOR_WIDTH   = 4,
  parameter int LAYER_LATENCY = 1,
  parameter int GRID_SHIFT    = 3
) (
  input  logic                                  vga_pix_clk,
  input  logic                                  rst,
  input  logic                                  frame_stb,
  input  logic [H_ADDR_WIDTH-1:0]               sx,
  input  logic [V_ADDR_WIDTH-1:0]               sy,
  input  logic                                  display_enabled,
  input  logic [NUM_LAYERS*H_ADDR_WIDTH-1:0]    cfg_x,
  input  logic [NUM_LAYERS*H_ADDR_WIDTH-1:0]    cfg_w,
  input  logic [NUM_LAYERS*V_ADDR_WIDTH-1:0]    cfg_y,
  input  logic [NUM_LAYERS*V_ADDR_WIDTH-1:0]    cfg_h,
  input  logic [NUM_LAYERS-1:0]                 cfg_en,
  input  logic [1:0]                            cfg_debug,
  input  logic [3*COLOR_WIDTH-1:0]              bg_rgb,
  output logic [NUM_LAYERS*H_ADDR_WIDTH-1:0]    layer_sx,
  output logic [NUM_LAYERS*V_ADDR_WIDTH-1:0]    layer_sy,
  output logic [NUM_LAYERS-1:0]                 layer_active,
  input  logic [NUM_LAYERS*3*COLOR_WIDTH-1:0]   layer_rgb,
  input  logic [NUM_LAYERS-1:0]                 layer_opaque,
  output logic [COLOR_WIDTH-1:0]                R,
  output logic [COLOR_WIDTH-1:0]                G,
  output logic [COLOR_WIDTH-1:0]                B,
  output logic                                  de_out
);

  // Timing contract (no stalls, one pixel per cycle): layer_sx/sy/active are registered one
  // cycle after sx/sy; layer_rgb/opaque must answer exactly LAYER_LATENCY cycles later; R/G/B
  // and de_out follow sx by LAYER_LATENCY+2 cycles.
  localparam int HW = H_ADDR_WIDTH;
  localparam int VW = V_ADDR_WIDTH;
  localparam int NL = NUM_LAYERS;
  localparam int CW = COLOR_WIDTH;
  localparam int PW = 3 * COLOR_WIDTH;
  localparam int GS = GRID_SHIFT;
  localparam int DW = 1 + 2 * NL + 2 * GS;
  localparam logic [HW-1:0] H_ONE = HW'(1);
  localparam logic [VW-1:0] V_ONE = VW'(1);

  logic [NL*HW-1:0] sh_x, sh_w;
  logic [NL*VW-1:0] sh_y, sh_h;
  logic [NL-1:0]    sh_en;
  logic [1:0]       sh_debug;

  always_ff @(posedge vga_pix_clk) begin
    if (rst) begin
      sh_x     <= '0;
      sh_w     <= '0;
      sh_y     <= '0;
      sh_h     <= '0;
      sh_en    <= '0;
      sh_debug <= '0;
    end else if (frame_stb) begin
      sh_x     <= cfg_x;
      sh_w     <= cfg_w;
      sh_y     <= cfg_y;
      sh_h     <= cfg_h;
      sh_en    <= cfg_en;
      sh_debug <= cfg_debug;
    end
  end

  // Stage A: window hit test; end coordinates are one bit wider so x+w never wraps.
  logic [NL-1:0]    hit_c, border_c;
  logic [NL*HW-1:0] lx_c;
  logic [NL*VW-1:0] ly_c;

  always_comb begin
    hit_c    = '0;
    border_c = '0;
    lx_c     = '0;
    ly_c     = '0;
    for (int i = 0; i < NL; i++) begin
      hit_c[i] = display_enabled & sh_en[i]
               & (sx >= sh_x[i*HW +: HW])
               & ({1'b0, sx} < ({1'b0, sh_x[i*HW +: HW]} + {1'b0, sh_w[i*HW +: HW]}))
               & (sy >= sh_y[i*VW +: VW])
               & ({1'b0, sy} < ({1'b0, sh_y[i*VW +: VW]} + {1'b0, sh_h[i*VW +: VW]}));
      if (hit_c[i]) begin
        lx_c[i*HW +: HW] = sx - sh_x[i*HW +: HW];
        ly_c[i*VW +: VW] = sy - sh_y[i*VW +: VW];
        border_c[i] = (lx_c[i*HW +: HW] == '0)
                    | (lx_c[i*HW +: HW] == sh_w[i*HW +: HW] - H_ONE)
                    | (ly_c[i*VW +: VW] == '0)
                    | (ly_c[i*VW +: VW] == sh_h[i*VW +: VW] - V_ONE);
      end
    end
  end

  logic          a_de;
  logic [NL-1:0] a_border;
  logic [GS-1:0] a_gx, a_gy;

  always_ff @(posedge vga_pix_clk) begin
    if (rst) begin
      layer_sx     <= '0;
      layer_sy     <= '0;
      layer_active <= '0;
      a_border     <= '0;
      a_de         <= 1'b0;
      a_gx         <= '0;
      a_gy         <= '0;
    end else begin
      layer_sx     <= lx_c;
      layer_sy     <= ly_c;
      layer_active <= hit_c;
      a_border     <= border_c;
      a_de         <= display_enabled;
      a_gx         <= sx[GS-1:0];
      a_gy         <= sy[GS-1:0];
    end
  end

  // Side-band delay line matching the renderer latency.
  logic [DW-1:0] dl [LAYER_LATENCY];
  logic          d_de;
  logic [NL-1:0] d_act, d_border;
  logic [GS-1:0] d_gx, d_gy;

  always_ff @(posedge vga_pix_clk) begin
    if (rst) begin
      for (int k = 0; k < LAYER_LATENCY; k++) dl[k] <= '0;
    end else begin
      dl[0] <= {a_de, layer_active, a_border, a_gx, a_gy};
      for (int k = 1; k < LAYER_LATENCY; k++) dl[k] <= dl[k-1];
    end
  end

  assign {d_de, d_act, d_border, d_gx, d_gy} = dl[LAYER_LATENCY-1];

  // Stage B: ascending scan so the highest opaque active layer wins.
  logic          win;
  logic [3:0]    win_idx, idx_p1;
  logic [PW-1:0] px;

  always_comb begin
    win     = 1'b0;
    win_idx = '0;
    idx_p1  = '0;
    px      = bg_rgb;
    for (int i = 0; i < NL; i++) begin
      if (d_act[i] & layer_opaque[i]) begin
        win     = 1'b1;
        win_idx = 4'(i);
        px      = layer_rgb[i*PW +: PW];
      end
    end
    idx_p1 = win_idx + 4'd1;
    case (sh_debug)
      2'd1: begin
        px[PW-1 -: CW]    = px[PW-1 -: CW] ^ {CW{d_gx == '0}};
        px[PW-CW-1 -: CW] = px[PW-CW-1 -: CW] ^ {CW{d_gy == '0}};
      end
      2'd2: px = win ? {3{CW'(idx_p1)}} : '0;
      2'd3: if (|(d_act & d_border)) px = '1;
      default: ;
    endcase
    if (!d_de) px = '0;
  end

  always_ff @(posedge vga_pix_clk) begin
    if (rst) begin
      R      <= '0;
      G      <= '0;
      B      <= '0;
      de_out <= 1'b0;
    end else begin
      R      <= px[PW-1 -: CW];
      G      <= px[PW-CW-1 -: CW];
      B      <= px[CW-1:0];
      de_out <= d_de;
    end
  end

endmodule
